// File: rtl/data_addr_gen_pkg.sv
// Shared definitions for the data address generator: register class codes
// and default address/data widths.
// Latency: n/a (definitions only). Backpressure: n/a.
package data_addr_gen_pkg;

    localparam int DEF_DMA_SIZE = 16;
    localparam int DEF_DMD_SIZE = 16;

    // Upper two bits of the ureg address select the register class.
    typedef enum logic [1:0] {
        CLS_I = 2'b00,
        CLS_M = 2'b01,
        CLS_L = 2'b10,
        CLS_B = 2'b11
    } reg_class_t;

endpackage

// File: rtl/dag_circ_modify.sv
// Circular-buffer index update: next = I + mod, folded back into [B, B+L)
// by a single correction when L is non-zero.
// Latency: purely combinational. Backpressure: none.
// Ports: i (index), mod (two's complement modifier), l (length), b (base),
//        next_i (updated index).
module dag_circ_modify #(
    parameter int W = 16
) (
    input  logic [W-1:0] i,
    input  logic [W-1:0] mod,
    input  logic [W-1:0] l,
    input  logic [W-1:0] b,
    output logic [W-1:0] next_i
);

    logic [W-1:0] sum;
    logic [W:0]   sum_x;
    logic [W:0]   lim;
    logic [W:0]   base_x;

    assign sum    = i + mod;
    // One extra bit so B+L near the top of the address space cannot wrap.
    assign sum_x  = {1'b0, sum};
    assign base_x = {1'b0, b};
    assign lim    = {1'b0, b} + {1'b0, l};

    always_comb begin
        next_i = sum;
        if (l != '0) begin
            if (!mod[W-1] && (sum_x >= lim)) begin
                next_i = sum - l;
            end else if (mod[W-1] && (sum_x < base_x)) begin
                next_i = sum + l;
            end
        end
    end

endmodule

// File: rtl/data_addr_gen.sv
// Data memory address generator with I/M/L/B register file, pre/post-modify
// addressing, circular buffers and a ureg read/write port.
// Latency: access address is combinational; ureg read data is 1 cycle.
// Backpressure: none, an access or ureg op is accepted on every cycle.
// Ports: clk, reset (async active-low); ps_dg_* access and ureg controls;
//        bc_dg_dt write data; dg_dm_add memory address; dg_bc_dt read data.
module data_addr_gen
    import data_addr_gen_pkg::*;
#(
    parameter int DMA_SIZE = DEF_DMA_SIZE,
    parameter int DMD_SIZE = DEF_DMD_SIZE
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ps_dg_en,
    input  logic                ps_dg_pre,
    input  logic [1:0]          ps_dg_isel,
    input  logic [1:0]          ps_dg_msel,
    input  logic                ps_dg_imm_en,
    input  logic [DMA_SIZE-1:0] ps_dg_imm,
    input  logic                ps_dg_wrt_en,
    input  logic [3:0]          ps_dg_ureg_add,
    input  logic [DMD_SIZE-1:0] bc_dg_dt,
    input  logic                ps_dg_rd_en,
    output logic [DMA_SIZE-1:0] dg_dm_add,
    output logic [DMD_SIZE-1:0] dg_bc_dt
);

    logic [DMA_SIZE-1:0] ir [4];
    logic [DMA_SIZE-1:0] mr [4];
    logic [DMA_SIZE-1:0] lr [4];
    logic [DMA_SIZE-1:0] br [4];
    logic [DMA_SIZE-1:0] addr_q;

    logic [DMA_SIZE-1:0] cur_i;
    logic [DMA_SIZE-1:0] mod;
    logic [DMA_SIZE-1:0] next_i;
    logic [DMA_SIZE-1:0] acc_add;
    logic [DMA_SIZE-1:0] wr_val;
    logic [DMA_SIZE-1:0] rd_val;
    reg_class_t          ureg_cls;
    logic [1:0]          ureg_idx;

    assign ureg_cls = reg_class_t'(ps_dg_ureg_add[3:2]);
    assign ureg_idx = ps_dg_ureg_add[1:0];
    assign wr_val   = bc_dg_dt[DMA_SIZE-1:0];

    assign cur_i   = ir[ps_dg_isel];
    assign mod     = ps_dg_imm_en ? ps_dg_imm : mr[ps_dg_msel];
    // Pre-modify is a plain modular add; circular folding applies only to
    // the post-modify writeback.
    assign acc_add = ps_dg_pre ? (cur_i + mod) : cur_i;

    dag_circ_modify #(.W(DMA_SIZE)) u_circ (
        .i      (cur_i),
        .mod    (mod),
        .l      (lr[ps_dg_isel]),
        .b      (br[ps_dg_isel]),
        .next_i (next_i)
    );

    // Forced to zero while reset is low so the memory never sees a stale
    // combinational address during reset.
    assign dg_dm_add = !reset ? '0 : (ps_dg_en ? acc_add : addr_q);

    always_comb begin
        rd_val = '0;
        case (ureg_cls)
            CLS_I:   rd_val = ir[ureg_idx];
            CLS_M:   rd_val = mr[ureg_idx];
            CLS_L:   rd_val = lr[ureg_idx];
            CLS_B:   rd_val = br[ureg_idx];
            default: rd_val = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < 4; k++) begin
                ir[k] <= '0;
                mr[k] <= '0;
                lr[k] <= '0;
                br[k] <= '0;
            end
            addr_q   <= '0;
            dg_bc_dt <= '0;
        end else begin
            if (ps_dg_en) begin
                addr_q <= acc_add;
            end
            if (ps_dg_en && !ps_dg_pre) begin
                ir[ps_dg_isel] <= next_i;
            end
            // Placed after the post-modify update so a ureg write to the same
            // I register takes precedence.
            if (ps_dg_wrt_en) begin
                case (ureg_cls)
                    CLS_I: ir[ureg_idx] <= wr_val;
                    CLS_M: mr[ureg_idx] <= wr_val;
                    CLS_L: lr[ureg_idx] <= wr_val;
                    CLS_B: begin
                        br[ureg_idx] <= wr_val;
                        ir[ureg_idx] <= wr_val;
                    end
                    default: ;
                endcase
            end
            if (ps_dg_rd_en) begin
                dg_bc_dt <= DMD_SIZE'(rd_val);
            end
        end
    end

endmodule

// File: tb/tb_data_addr_gen.sv
module tb_data_addr_gen;

    localparam int DMA  = 16;
    localparam int DMD  = 16;
    localparam int FULL = 1 << DMA;
    localparam int MASK = FULL - 1;
    localparam int HALF = 1 << (DMA - 1);

    localparam logic [1:0] CI = 2'b00;
    localparam logic [1:0] CM = 2'b01;
    localparam logic [1:0] CL = 2'b10;
    localparam logic [1:0] CB = 2'b11;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           ps_dg_en = 1'b0;
    logic           ps_dg_pre = 1'b0;
    logic [1:0]     ps_dg_isel = '0;
    logic [1:0]     ps_dg_msel = '0;
    logic           ps_dg_imm_en = 1'b0;
    logic [DMA-1:0] ps_dg_imm = '0;
    logic           ps_dg_wrt_en = 1'b0;
    logic [3:0]     ps_dg_ureg_add = '0;
    logic [DMD-1:0] bc_dg_dt = '0;
    logic           ps_dg_rd_en = 1'b0;
    logic [DMA-1:0] dg_dm_add;
    logic [DMD-1:0] dg_bc_dt;

    int n_checks = 0;
    int n_errors = 0;
    bit started = 1'b0;

    always #5 clk = ~clk;

    data_addr_gen #(.DMA_SIZE(DMA), .DMD_SIZE(DMD)) dut (
        .clk            (clk),
        .reset          (reset),
        .ps_dg_en       (ps_dg_en),
        .ps_dg_pre      (ps_dg_pre),
        .ps_dg_isel     (ps_dg_isel),
        .ps_dg_msel     (ps_dg_msel),
        .ps_dg_imm_en   (ps_dg_imm_en),
        .ps_dg_imm      (ps_dg_imm),
        .ps_dg_wrt_en   (ps_dg_wrt_en),
        .ps_dg_ureg_add (ps_dg_ureg_add),
        .bc_dg_dt       (bc_dg_dt),
        .ps_dg_rd_en    (ps_dg_rd_en),
        .dg_dm_add      (dg_dm_add),
        .dg_bc_dt       (dg_bc_dt)
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int mi [4];
    int mm [4];
    int ml [4];
    int mb [4];
    int m_held;
    int m_rd;

    function automatic int to_signed(input int v);
        return (v >= HALF) ? v - FULL : v;
    endfunction

    function automatic int circ(input int i, input int md, input int l, input int b);
        int sm;
        int n;
        sm = to_signed(md);
        n  = (i + sm) & MASK;
        if (l != 0) begin
            if (sm >= 0 && n >= b + l) n = n - l;
            else if (sm < 0 && n < b) n = n + l;
        end
        return n & MASK;
    endfunction

    function automatic int cur_mod();
        return ps_dg_imm_en ? int'(ps_dg_imm) : mm[ps_dg_msel];
    endfunction

    function automatic int m_addr();
        int i;
        if (!ps_dg_en) return m_held;
        i = mi[ps_dg_isel];
        return ps_dg_pre ? ((i + cur_mod()) & MASK) : i;
    endfunction

    function automatic int m_reg(input logic [3:0] a);
        case (a[3:2])
            2'b00:   return mi[a[1:0]];
            2'b01:   return mm[a[1:0]];
            2'b10:   return ml[a[1:0]];
            default: return mb[a[1:0]];
        endcase
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < 4; k++) begin
                mi[k] <= 0; mm[k] <= 0; ml[k] <= 0; mb[k] <= 0;
            end
            m_held <= 0;
            m_rd   <= 0;
        end else begin
            if (ps_dg_en) m_held <= m_addr();
            if (ps_dg_en && !ps_dg_pre)
                mi[ps_dg_isel] <= circ(mi[ps_dg_isel], cur_mod(),
                                       ml[ps_dg_isel], mb[ps_dg_isel]);
            if (ps_dg_wrt_en) begin
                case (ps_dg_ureg_add[3:2])
                    2'b00: mi[ps_dg_ureg_add[1:0]] <= int'(bc_dg_dt) & MASK;
                    2'b01: mm[ps_dg_ureg_add[1:0]] <= int'(bc_dg_dt) & MASK;
                    2'b10: ml[ps_dg_ureg_add[1:0]] <= int'(bc_dg_dt) & MASK;
                    default: begin
                        mb[ps_dg_ureg_add[1:0]] <= int'(bc_dg_dt) & MASK;
                        mi[ps_dg_ureg_add[1:0]] <= int'(bc_dg_dt) & MASK;
                    end
                endcase
            end
            if (ps_dg_rd_en) m_rd <= m_reg(ps_dg_ureg_add);
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (started && reset) begin
            chk("model_addr", int'(dg_dm_add), m_addr());
            chk("model_rd", int'(dg_bc_dt), m_rd);
        end
    end

    // ---------------- directed stimulus ----------------
    // All tasks start and end 1 time unit after a rising edge.
    task automatic wr(input logic [1:0] cls, input logic [1:0] idx, input int val);
        ps_dg_wrt_en   = 1'b1;
        ps_dg_ureg_add = {cls, idx};
        bc_dg_dt       = DMD'(val);
        @(posedge clk); #1;
        ps_dg_wrt_en   = 1'b0;
    endtask

    task automatic rd(input string nm, input logic [1:0] cls, input logic [1:0] idx,
                      input int exp);
        ps_dg_rd_en    = 1'b1;
        ps_dg_ureg_add = {cls, idx};
        @(posedge clk); #1;
        ps_dg_rd_en    = 1'b0;
        chk(nm, int'(dg_bc_dt), exp);
    endtask

    task automatic acc(input string nm, input bit pre, input logic [1:0] isel,
                       input logic [1:0] msel, input bit imm_en, input int imm,
                       input int exp);
        ps_dg_en     = 1'b1;
        ps_dg_pre    = pre;
        ps_dg_isel   = isel;
        ps_dg_msel   = msel;
        ps_dg_imm_en = imm_en;
        ps_dg_imm    = DMA'(imm);
        @(negedge clk);
        chk(nm, int'(dg_dm_add), exp);
        @(posedge clk); #1;
        ps_dg_en     = 1'b0;
        ps_dg_imm_en = 1'b0;
    endtask

    initial begin
        #2;
        chk("reset_addr", int'(dg_dm_add), 0);
        chk("reset_rd", int'(dg_bc_dt), 0);
        #10 reset = 1'b1;              // released between edges
        @(posedge clk); #1;
        started = 1'b1;

        // Linear post-modify
        wr(CI, 0, 'h0010); wr(CM, 0, 'h0002); wr(CL, 0, 0);
        acc("lin0", 0, 0, 0, 0, 0, 'h0010);
        acc("lin1", 0, 0, 0, 0, 0, 'h0012);
        acc("lin2", 0, 0, 0, 0, 0, 'h0014);
        rd("lin_i0", CI, 0, 'h0016);

        // Circular wrap, positive modifier
        wr(CB, 1, 'h0100); wr(CL, 1, 4); wr(CM, 1, 3);
        rd("b_loads_i", CI, 1, 'h0100);
        acc("circ0", 0, 1, 1, 0, 0, 'h0100);
        acc("circ1", 0, 1, 1, 0, 0, 'h0103);
        acc("circ2", 0, 1, 1, 0, 0, 'h0102);
        acc("circ3", 0, 1, 1, 0, 0, 'h0101);
        rd("circ_i1", CI, 1, 'h0100);
        rd("rd_l1", CL, 1, 4);
        rd("rd_b1", CB, 1, 'h0100);

        // Negative modifier
        wr(CM, 1, 'hFFFF); wr(CI, 1, 'h0100);
        acc("neg0", 0, 1, 1, 0, 0, 'h0100);
        acc("neg1", 0, 1, 1, 0, 0, 'h0103);
        rd("neg_i1", CI, 1, 'h0102);
        rd("rd_m1", CM, 1, 'hFFFF);

        // Pre-modify with immediate, then hold
        wr(CI, 2, 'h0020);
        acc("pre_imm", 1, 2, 0, 1, 'h0005, 'h0025);
        @(negedge clk);
        chk("hold_addr", int'(dg_dm_add), 'h0025);
        @(posedge clk); #1;
        rd("pre_i2", CI, 2, 'h0020);

        // Collision of post-modify and ureg write on I3
        wr(CI, 3, 'h0040); wr(CM, 3, 1);
        ps_dg_wrt_en = 1'b1; ps_dg_ureg_add = {CI, 2'd3}; bc_dg_dt = 'h0080;
        acc("coll_addr", 0, 3, 3, 0, 0, 'h0040);
        ps_dg_wrt_en = 1'b0;
        rd("coll_i3", CI, 3, 'h0080);

        // Access using M0 while M0 is being written: pre-write value applies
        ps_dg_wrt_en = 1'b1; ps_dg_ureg_add = {CM, 2'd0}; bc_dg_dt = 'h0005;
        acc("nobypass_addr", 0, 0, 0, 0, 0, 'h0016);
        ps_dg_wrt_en = 1'b0;
        rd("nobypass_i0", CI, 0, 'h0018);
        rd("new_m0", CM, 0, 'h0005);
        acc("premod_m3", 1, 3, 3, 0, 0, 'h0081);

        // Async reset with an access in flight
        rd("pre_reset_rd", CI, 3, 'h0080);
        ps_dg_en = 1'b1; ps_dg_pre = 1'b0; ps_dg_isel = 2'd0; ps_dg_msel = 2'd0;
        #3 reset = 1'b0;
        #1;
        chk("arst_addr", int'(dg_dm_add), 0);
        chk("arst_rd", int'(dg_bc_dt), 0);
        ps_dg_en = 1'b0;
        @(posedge clk); @(posedge clk); #3;
        reset = 1'b1;
        @(posedge clk); #1;
        for (int c = 0; c < 4; c++) begin
            for (int k = 0; k < 4; k++) begin
                rd("post_reset_reg", 2'(c), 2'(k), 0);
            end
        end
        chk("post_reset_addr", int'(dg_dm_add), 0);

        @(posedge clk); #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/data_addr_gen.md
DATA_ADDR_GEN -- requirements
Module: data_addr_gen

Interface
REQ-001 The block SHALL have parameter DMA_SIZE, default 16, meaning data-memory address width.
REQ-002 The block SHALL have parameter DMD_SIZE, default 16, meaning data-bus width; DMD_SIZE >= DMA_SIZE.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 ps_dg_en  input  1  DM access request this cycle.
REQ-006 ps_dg_pre  input  1  1 = pre-modify, 0 = post-modify.
REQ-007 ps_dg_isel  input  2  index register select, I0..I3.
REQ-008 ps_dg_msel  input  2  modify register select, M0..M3.
REQ-009 ps_dg_imm_en  input  1  use ps_dg_imm instead of M[msel].
REQ-010 ps_dg_imm  input  DMA_SIZE  signed immediate modifier.
REQ-011 ps_dg_wrt_en  input  1  ureg write strobe.
REQ-012 ps_dg_ureg_add  input  4  register address: [3:2] class (00 I, 01 M, 10 L, 11 B), [1:0] index; shared by write and read.
REQ-013 bc_dg_dt  input  DMD_SIZE  write data from the bus connect.
REQ-014 ps_dg_rd_en  input  1  ureg read strobe.
REQ-015 dg_dm_add  output  DMA_SIZE  DM address, sampled by data memory on the next rising edge.
REQ-016 dg_bc_dt  output  DMD_SIZE  registered read data, zero-extended.

Function
REQ-017 State: 4 each of I, M, L, B registers, DMA_SIZE wide; M is two's complement.
REQ-018 Modifier mod = ps_dg_imm_en ? ps_dg_imm : M[msel].
REQ-019 Pre-modify (ps_dg_en=1, ps_dg_pre=1): dg_dm_add = I+mod combinationally, modulo 2^DMA_SIZE, no circular wrap; I unchanged.
REQ-020 Post-modify (ps_dg_en=1, ps_dg_pre=0): dg_dm_add = I combinationally; at the rising edge I <= circ(I,mod).
REQ-021 circ(I,mod) for L=0: I+mod modulo 2^DMA_SIZE.
REQ-022 circ(I,mod) for L!=0: n=I+mod; if mod>=0 and n>=B+L then n-L; if mod<0 and n<B then n+L; else n. Compares use DMA_SIZE+1-bit unsigned values.
REQ-023 ps_dg_en=0: dg_dm_add holds the last driven address (held register); no I update.
REQ-024 ureg write: on a rising edge with ps_dg_wrt_en=1, the addressed register <= bc_dg_dt[DMA_SIZE-1:0].
REQ-025 A write to B[n] also loads I[n] with the same value.
REQ-026 Same-edge ureg write and post-modify update to the same I[n]: the ureg write wins.
REQ-027 An access in the same cycle as a ureg write to its I/M/L/B uses pre-write values; there is no bypass.
REQ-028 ureg read: on a rising edge with ps_dg_rd_en=1, dg_bc_dt <= zero-extended addressed register (pre-write value); otherwise dg_bc_dt holds.
REQ-029 Read latency is 1 cycle. Access address has 0-cycle combinational latency from the inputs.
REQ-030 |mod| >= L with L!=0 is unsupported; single correction only, result unspecified.

Reset
REQ-031 reset=0 SHALL asynchronously clear all I, M, L, B registers, the held address, and dg_bc_dt to 0; dg_dm_add=0 while reset is asserted.
REQ-032 An access in flight at reset assertion SHALL be discarded, with no I update.

Structure
REQ-033 A shared package SHALL hold the register class codes (I=2'b00, M=2'b01, L=2'b10, B=2'b11) and default widths.
REQ-034 The circular add/wrap SHALL be a combinational sub-module dag_circ_modify (inputs I, mod, L, B; output next I).

Verification
REQ-035 Linear post-modify: write I0=0x0010, M0=0x0002, L0=0; three post-modify accesses -> dg_dm_add 0x0010, 0x0012, 0x0014; I0 ends 0x0016.
REQ-036 Circular wrap: write B1=0x0100 (I1 becomes 0x0100), L1=4, M1=3; post-modify x4 -> 0x0100, 0x0103, 0x0102, 0x0101.
REQ-037 Negative modify: B1=0x0100, L1=4, M1=0xFFFF (-1), I1=0x0100; post-modify x2 -> 0x0100, 0x0103.
REQ-038 Pre-modify with immediate: I2=0x0020, imm=0x0005, pre=1 -> dg_dm_add=0x0025, I2 stays 0x0020; ps_dg_en=0 next cycle -> dg_dm_add holds 0x0025.
REQ-039 Collision: post-modify on I3=0x0040, M3=1 in the same cycle as ureg write I3=0x0080 -> address 0x0040, I3=0x0080 afterwards; ureg read of I3 next cycle -> dg_bc_dt=0x0080 one cycle later.
REQ-040 Async reset mid-sequence: pull reset low between clock edges -> dg_dm_add and dg_bc_dt are 0 immediately; reads of all registers after release -> 0.
